// File: rtl/polyline_sequencer_if.sv
// Bundles the sequencer's two external buses: the synchronous vertex-memory
// read port and the start/done handshake with the line drawer.
interface polyline_sequencer_if #(
  parameter int ADDR_W = 4
);

  // Vertex memory read port (1-cycle synchronous read)
  logic [ADDR_W-1:0]  vtx_addr;
  logic signed [10:0] vtx_x;
  logic signed [10:0] vtx_y;

  // Line drawer request/acknowledge plus segment endpoints
  logic               line_start;
  logic signed [10:0] x0;
  logic signed [10:0] y0;
  logic signed [10:0] x1;
  logic signed [10:0] y1;
  logic               line_done;

  modport master (
    output vtx_addr,
    input  vtx_x,
    input  vtx_y,
    output line_start,
    output x0,
    output y0,
    output x1,
    output y1,
    input  line_done
  );

  modport slave (
    input  vtx_addr,
    output vtx_x,
    output vtx_y,
    input  line_start,
    input  x0,
    input  y0,
    input  x1,
    input  y1,
    output line_done
  );

endinterface

// File: rtl/polyline_sequencer.sv
// Walks a vertex list held in an external synchronous memory and hands each
// consecutive pair of vertices to a line drawer as one segment. Optionally
// closes the shape with a last->first segment. Every output is a register.
module polyline_sequencer #(
  parameter int ADDR_W = 4,
  parameter int CLOSED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_W:0]   seg_count,
  polyline_sequencer_if.master bus
);

  localparam logic [ADDR_W:0] N_MAX     = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] CNT_TWO   = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] CNT_THREE = (ADDR_W+1)'(3);

  typedef enum logic [3:0] {
    IDLE,
    FETCH0,
    LATCH0,
    FETCH,
    LATCH,
    ISSUE,
    RELEASE,
    NEXT,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W:0]    count_q;
  logic [ADDR_W:0]    count_clamped;
  logic [ADDR_W:0]    k;
  logic               closed_done;
  logic signed [10:0] first_x;
  logic signed [10:0] first_y;
  logic               more_vertices;
  logic               close_pending;

  // Decision terms: clamp the requested length to memory capacity, and decide
  // whether another vertex or the closing segment is still outstanding.
  always_comb begin
    count_clamped = count;
    if (count > N_MAX) begin
      count_clamped = N_MAX;
    end
    more_vertices = (k < count_q);
    close_pending = (CLOSED != 0) && (count_q >= CNT_THREE) && !closed_done;
  end

  // State register; reset wins over everything, including an in-flight segment.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Each segment is a full four-phase handshake so the
  // drawer always sees line_start low before the next request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (go) begin
          if (count_clamped < CNT_TWO) begin
            next_state = DONE;
          end else begin
            next_state = FETCH0;
          end
        end
      end
      FETCH0:  next_state = LATCH0;
      LATCH0:  next_state = FETCH;
      FETCH:   next_state = LATCH;
      LATCH:   next_state = ISSUE;
      ISSUE: begin
        if (bus.line_done) begin
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.line_done) begin
          next_state = NEXT;
        end
      end
      NEXT: begin
        if (more_vertices) begin
          next_state = FETCH;
        end else if (close_pending) begin
          next_state = ISSUE;
        end else begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered datapath and outputs. Strobes are derived from next_state so
  // they line up with the state they belong to without any input-to-output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy           <= 1'b0;
      finished       <= 1'b0;
      seg_count      <= '0;
      bus.line_start <= 1'b0;
      bus.vtx_addr   <= '0;
      bus.x0         <= '0;
      bus.y0         <= '0;
      bus.x1         <= '0;
      bus.y1         <= '0;
      count_q        <= '0;
      k              <= '0;
      closed_done    <= 1'b0;
      first_x        <= '0;
      first_y        <= '0;
    end else begin
      busy           <= (next_state != IDLE);
      finished       <= (next_state == DONE);
      bus.line_start <= (next_state == ISSUE);
      case (state)
        IDLE: begin
          if (go) begin
            count_q      <= count_clamped;
            seg_count    <= '0;
            k            <= (ADDR_W+1)'(1);
            closed_done  <= 1'b0;
            bus.vtx_addr <= '0;
          end
        end
        LATCH0: begin
          bus.x0       <= bus.vtx_x;
          bus.y0       <= bus.vtx_y;
          first_x      <= bus.vtx_x;
          first_y      <= bus.vtx_y;
          bus.vtx_addr <= k[ADDR_W-1:0];
        end
        LATCH: begin
          bus.x1 <= bus.vtx_x;
          bus.y1 <= bus.vtx_y;
          k      <= k + 1'b1;
        end
        RELEASE: begin
          if (!bus.line_done) begin
            seg_count <= seg_count + 1'b1;
          end
        end
        NEXT: begin
          bus.x0 <= bus.x1;
          bus.y0 <= bus.y1;
          if (more_vertices) begin
            bus.vtx_addr <= k[ADDR_W-1:0];
          end else if (close_pending) begin
            bus.x1      <= first_x;
            bus.y1      <= first_y;
            closed_done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polyline_sequencer.sv
// Scoreboard bench: one open and one closed sequencer share a vertex memory
// image; each has its own drawer model. Stimulus pushes hand-computed segments
// into a queue, and a monitor pops and compares on every line_start rise.
module tb_polyline_sequencer;

  localparam int AW = 4;

  typedef struct {
    logic signed [10:0] x0;
    logic signed [10:0] y0;
    logic signed [10:0] x1;
    logic signed [10:0] y1;
  } seg_t;

  logic           clk;
  logic           reset;
  logic           go;
  logic [AW:0]    count;
  int             sel;
  int             done_hold;

  logic signed [10:0] mem_x [16];
  logic signed [10:0] mem_y [16];

  logic [1:0]         ls_v;
  logic [1:0]         done_v;
  logic [1:0]         busy_v;
  logic [1:0]         fin_v;
  logic [AW:0]        segc_v [2];
  logic [AW-1:0]      vaddr  [2];
  logic signed [10:0] cx0 [2];
  logic signed [10:0] cy0 [2];
  logic signed [10:0] cx1 [2];
  logic signed [10:0] cy1 [2];

  seg_t exp_q [$];
  int   compared;
  int   failed;
  int   fin_seen;
  int   seg_seen;

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Instance 0 is open, instance 1 is closed
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    polyline_sequencer_if #(.ADDR_W(AW)) bus ();
    logic [2:0] start_cnt;
    logic [3:0] hold_cnt;

    polyline_sequencer #(.ADDR_W(AW), .CLOSED(gi)) dut (
      .clk(clk),
      .reset(reset),
      .go(go && (sel == gi)),
      .count(count),
      .busy(busy_v[gi]),
      .finished(fin_v[gi]),
      .seg_count(segc_v[gi]),
      .bus(bus)
    );

    // Synchronous-read vertex memory
    always @(posedge clk) begin
      bus.vtx_x <= mem_x[bus.vtx_addr];
      bus.vtx_y <= mem_y[bus.vtx_addr];
    end

    // Drawer model: done 5 cycles after start, held done_hold cycles after start drops
    always @(posedge clk) begin
      if (reset) begin
        bus.line_done <= 1'b0;
        start_cnt     <= '0;
        hold_cnt      <= '0;
      end else if (bus.line_done) begin
        if (!bus.line_start) begin
          if (int'(hold_cnt) >= done_hold) bus.line_done <= 1'b0;
          else hold_cnt <= hold_cnt + 1'b1;
        end
      end else if (bus.line_start) begin
        if (start_cnt == 3'd4) begin
          bus.line_done <= 1'b1;
          start_cnt     <= '0;
          hold_cnt      <= '0;
        end else begin
          start_cnt <= start_cnt + 1'b1;
        end
      end else begin
        start_cnt <= '0;
      end
    end

    assign ls_v[gi]   = bus.line_start;
    assign done_v[gi] = bus.line_done;
    assign vaddr[gi]  = bus.vtx_addr;
    assign cx0[gi]    = bus.x0;
    assign cy0[gi]    = bus.y0;
    assign cx1[gi]    = bus.x1;
    assign cy1[gi]    = bus.y1;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushSeg(input int a, input int b, input int c, input int d);
    seg_t s;
    s.x0 = 11'(a);
    s.y0 = 11'(b);
    s.x1 = 11'(c);
    s.y1 = 11'(d);
    exp_q.push_back(s);
  endtask

  task automatic loadVertex(input int idx, input int x, input int y);
    mem_x[idx] = 11'(x);
    mem_y[idx] = 11'(y);
  endtask

  // Pulse go for one edge; optionally check that line_start rises 4 edges later
  task automatic applyStimulus(input int which, input int n, input bit check_latency);
    int lat;
    @(negedge clk);
    sel      = which;
    count    = (AW+1)'(n);
    go       = 1'b1;
    fin_seen = 0;
    seg_seen = 0;
    @(posedge clk);
    #1 go = 1'b0;
    if (check_latency) begin
      lat = 0;
      while (!ls_v[which] && lat < 50) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checkOutput("start_latency", lat, 4);
    end
  endtask

  // Wait for completion, then check pulse count, seg_count and drained queue
  task automatic finishJob(input int exp_segs);
    int waited;
    waited = 0;
    while (fin_seen == 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (fin_seen == 0) begin
      compared++;
      failed++;
      $display("[TB] FAIL finish_timeout: got no finished pulse in %0d cycles, expected one", waited);
    end
    repeat (3) @(negedge clk);
    checkOutput("finished_pulses", fin_seen, 1);
    checkOutput("seg_count", segc_v[sel], exp_segs);
    checkOutput("segments_issued", seg_seen, exp_segs);
    checkOutput("busy_after_done", busy_v[sel], 0);
    checkOutput("pending_expected", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: on each line_start rise pop one expected segment and compare
  initial begin
    logic [1:0] ls_prev;
    seg_t e;
    ls_prev = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ls_v[i] && !ls_prev[i]) begin
          seg_seen++;
          checkOutput("start_while_done", done_v[i], 0);
          if (exp_q.size() == 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL unexpected_segment: got line_start on dut %0d, expected none", i);
          end else begin
            e = exp_q.pop_front();
            checkOutput("seg_x0", cx0[i], e.x0);
            checkOutput("seg_y0", cy0[i], e.y0);
            checkOutput("seg_x1", cx1[i], e.x1);
            checkOutput("seg_y1", cy1[i], e.y1);
          end
        end
        if (fin_v[i]) fin_seen++;
        ls_prev[i] = ls_v[i];
      end
    end
  end

  // Watchdog keeps the run bounded even if a wait loop misbehaves
  initial begin
    #1500000;
    failed++;
    $display("[TB] FAIL watchdog: got no completion, expected summary before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    int waited;
    compared  = 0;
    failed    = 0;
    reset     = 1'b1;
    go        = 1'b0;
    count     = '0;
    sel       = 0;
    done_hold = 0;
    for (int i = 0; i < 16; i++) loadVertex(i, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("[TB] reset values");
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_line_start", ls_v[i], 0);
      checkOutput("rst_busy", busy_v[i], 0);
      checkOutput("rst_finished", fin_v[i], 0);
      checkOutput("rst_vtx_addr", vaddr[i], 0);
      checkOutput("rst_coords_or", cx0[i] | cy0[i] | cx1[i] | cy1[i], 0);
      checkOutput("rst_seg_count", segc_v[i], 0);
    end
    reset = 1'b0;

    $display("[TB] open triangle");
    loadVertex(0, 10, 10);
    loadVertex(1, 20, 15);
    loadVertex(2, 13, 21);
    pushSeg(10, 10, 20, 15);
    pushSeg(20, 15, 13, 21);
    applyStimulus(0, 3, 1'b1);
    finishJob(2);

    $display("[TB] closed triangle, slow done release, go and count poked while busy");
    done_hold = 3;
    pushSeg(10, 10, 20, 15);
    pushSeg(20, 15, 13, 21);
    pushSeg(13, 21, 10, 10);
    applyStimulus(1, 3, 1'b1);
    @(negedge clk);
    go    = 1'b1;
    count = (AW+1)'(2);
    @(negedge clk);
    go = 1'b0;
    finishJob(3);
    done_hold = 0;

    $display("[TB] short lists");
    applyStimulus(1, 1, 1'b0);
    finishJob(0);
    applyStimulus(0, 0, 1'b0);
    finishJob(0);

    $display("[TB] two vertices closed, negative coordinates");
    loadVertex(0, -5, -5);
    loadVertex(1, 30, -20);
    pushSeg(-5, -5, 30, -20);
    applyStimulus(1, 2, 1'b1);
    finishJob(1);

    $display("[TB] degenerate and extreme coordinates");
    loadVertex(0, 7, 7);
    loadVertex(1, 7, 7);
    loadVertex(2, -1024, 1023);
    pushSeg(7, 7, 7, 7);
    pushSeg(7, 7, -1024, 1023);
    pushSeg(-1024, 1023, 7, 7);
    applyStimulus(1, 3, 1'b1);
    finishJob(3);

    $display("[TB] reset during second segment");
    loadVertex(0, 10, 10);
    loadVertex(1, 20, 15);
    loadVertex(2, 13, 21);
    pushSeg(10, 10, 20, 15);
    pushSeg(20, 15, 13, 21);
    applyStimulus(1, 3, 1'b1);
    waited = 0;
    while (seg_seen < 2 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reached_second_segment", seg_seen, 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_line_start", ls_v[1], 0);
    checkOutput("reset_busy", busy_v[1], 0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_seg_count", segc_v[1], 0);
    checkOutput("reset_pending", exp_q.size(), 0);
    exp_q.delete();
    pushSeg(10, 10, 20, 15);
    pushSeg(20, 15, 13, 21);
    pushSeg(13, 21, 10, 10);
    applyStimulus(1, 3, 1'b1);
    finishJob(3);

    $display("[TB] full memory, oversized count clamps");
    for (int i = 0; i < 16; i++) loadVertex(i, 3 * i - 20, 100 - 7 * i);
    for (int i = 0; i < 15; i++) pushSeg(3 * i - 20, 100 - 7 * i, 3 * i - 17, 93 - 7 * i);
    applyStimulus(0, 31, 1'b1);
    finishJob(15);
    for (int i = 0; i < 15; i++) pushSeg(3 * i - 20, 100 - 7 * i, 3 * i - 17, 93 - 7 * i);
    pushSeg(25, -5, -20, 100);
    applyStimulus(1, 16, 1'b1);
    finishJob(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/polyline_sequencer.md
POLYLINE_SEQUENCER -- requirements
Module: polyline_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 4, vertex address width; capacity N_MAX = 2**ADDR_W vertices.
REQ-002 Parameter: CLOSED, default 1, 1 = append closing segment last->first vertex.
REQ-003 Clock clk; reset reset, synchronous, active-high.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 go  input  1  request to draw the stored polyline; sampled only in IDLE.
REQ-007 count  input  ADDR_W+1  number of vertices; latched on accepted go.
REQ-008 vtx_addr  output  ADDR_W  vertex memory read address.
REQ-009 vtx_x, vtx_y  input  11 signed each  vertex data; valid the cycle after vtx_addr is sampled (1-cycle synchronous read).
REQ-010 line_start  output  1  start request to the line drawer.
REQ-011 x0, y0, x1, y1  output  11 signed each  current segment endpoints.
REQ-012 line_done  input  1  line drawer done flag.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 finished  output  1  one-cycle pulse when the polyline is complete.
REQ-015 seg_count  output  ADDR_W+1  segments completed since last accepted go.

Function
REQ-016 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-017 States SHALL be IDLE, FETCH0, LATCH0, FETCH, LATCH, ISSUE, RELEASE, NEXT, DONE.
REQ-018 IDLE: go=1 -> FETCH0, latch count (values > N_MAX clamped to N_MAX), clear seg_count, vertex index k=1.
REQ-019 count < 2 on accepted go: FETCH0 skipped, -> DONE directly; no line_start issued.
REQ-020 FETCH0 drives vtx_addr=0; LATCH0 captures vtx_x/vtx_y into x0/y0 and a private first-vertex register.
REQ-021 FETCH drives vtx_addr=k; LATCH captures vtx_x/vtx_y into x1/y1, k<=k+1, -> ISSUE.
REQ-022 line_start SHALL first rise on the 4th rising edge after the edge that samples go.
REQ-023 ISSUE: line_start=1 held with x0..y1 stable until line_done=1 sampled, then -> RELEASE.
REQ-024 RELEASE: line_start=0; remain until line_done=0 sampled, then -> NEXT, seg_count+1.
REQ-025 line_start SHALL be low for at least one cycle between consecutive segments, and SHALL NOT reassert while line_done=1.
REQ-026 NEXT: x0,y0 <= x1,y1; if k < count -> FETCH; else if CLOSED=1, count>=3 and closing segment not yet drawn -> x1,y1 <= first vertex, -> ISSUE; else -> DONE.
REQ-027 count=2 SHALL draw exactly one segment regardless of CLOSED.
REQ-028 DONE: finished=1 for exactly one cycle, -> IDLE.
REQ-029 go while busy SHALL be ignored; count changes while busy SHALL have no effect.
REQ-030 k and seg_count SHALL not wrap: count=N_MAX draws N_MAX-1 (+1 if closed) segments.
REQ-031 Coordinates SHALL pass through unmodified (no clipping, no sign change); degenerate segments (x0=x1, y0=y1) SHALL still be issued.

Reset
REQ-032 reset=1 SHALL force IDLE on the next edge, overriding all other inputs, including mid-ISSUE.
REQ-033 Reset values: line_start=0, busy=0, finished=0, vtx_addr=0, x0=y0=x1=y1=0, seg_count=0.
REQ-034 After reset, the first go SHALL behave identically to power-up.

Verification
REQ-035 Open triangle: CLOSED=0, count=3, vertices (10,10),(20,15),(13,21); drawer model asserts done 5 cycles after start -> segments (10,10)-(20,15), (20,15)-(13,21); seg_count=2; one finished pulse.
REQ-036 Closed triangle: CLOSED=1, same vertices -> third segment (13,21)-(10,10); seg_count=3.
REQ-037 Timing: go sampled at edge E -> line_start high after edge E+4; holding line_done=1 for 3 extra cycles after start drops -> no new line_start until line_done low.
REQ-038 count=1 and count=0 -> finished pulse, line_start never asserted, seg_count=0; count=2 with CLOSED=1 -> exactly one segment.
REQ-039 Negative coordinates: vertices (-5,-5),(30,-20) -> x0=-5, y0=-5, x1=30, y1=-20 exactly.
REQ-040 Reset asserted during second segment's ISSUE -> line_start=0, busy=0 next cycle; subsequent go restarts from vertex 0; go pulsed while busy -> ignored.
